split_incr_counter: RTL and testbench

- Wide free-running sequence counter built as a two-stage carry-deferred pipeline from a LO_W-bit fast incrementor and a (WIDTH-LO_W)-bit fast incrementor.
- The carry out of the low half is registered and applied to the high half one cycle later. This keeps the per-cycle critical path at one narrow incrementor.
- Sits directly downstream of the incrementor blocks and registers their out/cy results.
- Presents coherent count values to a consumer over a valid/ready handshake.

---
 rtl/split_incr_counter.sv | 141 ++++++++++++++
 tb/tb_split_incr_counter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/split_incr_counter.sv
// Purpose    : wide free-running sequence counter, low half counts every transfer,
//              high half absorbs the low-half carry one cycle later (carry-deferred).
// Latency    : load to first valid count is 1 cycle; 1 count/cycle, 1 bubble per low wrap.
// Backpressure: out_count holds while out_valid && !out_ready; advances only on transfer.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   load       load load_val and start counting (highest priority after reset)
//   load_val   value to load, {hi, lo}
//   stop       halt counting; out_valid drops the next cycle
//   out_ready  consumer accepts out_count this cycle
//   out_valid  out_count is coherent and offered
//   out_count  current count {hi, lo}, straight from the state registers
//   wrap       one-cycle pulse: full-width wrap all-ones -> 0 completed
//   carry_pend low-half carry pending; high half not yet updated

// Purpose    : log-depth incrementor, out = a + 1, cy = (a is all-ones).
// Latency    : combinational.
// Backpressure: none.
module fast_incr #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] out,
    output logic         cy
);

    // pfx[i] = &a[i:0], built with a Kogge-Stone style AND prefix so the
    // depth grows with log2(W) rather than W.
    logic [W-1:0] pfx;
    logic [W-1:0] pfx_prev;
    logic [W:0]   pfx_shift;

    always_comb begin
        pfx      = a;
        pfx_prev = a;
        for (int s = 1; s < W; s = s * 2) begin
            pfx_prev = pfx;
            for (int i = 0; i < W; i++) begin
                if (i >= s) begin
                    pfx[i] = pfx_prev[i] & pfx_prev[i-s];
                end
            end
        end
    end

    // Bit i toggles when every lower bit is one; bit 0 always toggles.
    assign pfx_shift = {pfx, 1'b1};
    assign out       = a ^ pfx_shift[W-1:0];
    assign cy        = pfx[W-1];

endmodule

// Purpose    : carry-deferred split counter with valid/ready output.
// Latency    : registered outputs; load visible next cycle; hi lags lo carry by 1 cycle.
// Backpressure: no advance without transfer; carry cycle forces out_valid low.
module split_incr_counter #(
    parameter int WIDTH = 32,
    parameter int LO_W  = 16   // WIDTH must exceed LO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             stop,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_count,
    output logic             wrap,
    output logic             carry_pend
);

    localparam int HI_W = WIDTH - LO_W;

    logic [LO_W-1:0] lo;
    logic [HI_W-1:0] hi;
    logic            carry_q;
    logic            running;
    logic            wrap_q;

    logic [LO_W-1:0] lo_inc;
    logic            lo_cy;
    logic [HI_W-1:0] hi_inc;
    logic            hi_cy;
    logic            xfer;

    fast_incr #(.W(LO_W)) u_lo_incr (
        .a   (lo),
        .out (lo_inc),
        .cy  (lo_cy)
    );

    fast_incr #(.W(HI_W)) u_hi_incr (
        .a   (hi),
        .out (hi_inc),
        .cy  (hi_cy)
    );

    // While the carry is in flight {hi, lo} is incoherent, so the value is
    // withheld; this also guarantees a transfer and a carry never coincide.
    assign out_valid  = running && !carry_q;
    assign xfer       = out_valid && out_ready;
    assign out_count  = {hi, lo};
    assign wrap       = wrap_q;
    assign carry_pend = carry_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo      <= '0;
            hi      <= '0;
            carry_q <= 1'b0;
            running <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (load) begin
            // Any coincident increment or pending carry is discarded.
            lo      <= load_val[LO_W-1:0];
            hi      <= load_val[WIDTH-1:LO_W];
            carry_q <= 1'b0;
            running <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (carry_q) begin
                // hi all-ones rolling to zero completes the full-width wrap.
                hi      <= hi_inc;
                carry_q <= 1'b0;
                wrap_q  <= hi_cy;
            end else if (xfer) begin
                lo      <= lo_inc;
                carry_q <= lo_cy;
            end
            // Stop only gates future offers; the transfer or carry above
            // still completes so the held value stays exact.
            if (stop) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_split_incr_counter.sv
module tb_split_incr_counter;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] load_val;
    logic        stop;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_count;
    logic        wrap;
    logic        carry_pend;

    int checks;
    int failures;

    split_incr_counter #(.WIDTH(32), .LO_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val),
        .stop       (stop),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_count  (out_count),
        .wrap       (wrap),
        .carry_pend (carry_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; load_val = '0; stop = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, out_valid);
            end
            checks++;
            if (out_count !== 32'h0) begin
                failures++; $display("FAIL reset_count cyc=%0d got=%h exp=00000000", c, out_count);
            end
            checks++;
            if (wrap !== 1'b0 || carry_pend !== 1'b0) begin
                failures++; $display("FAIL reset_flags cyc=%0d wrap=%b carry_pend=%b exp=0,0", c, wrap, carry_pend);
            end
            tick();
        end
    endtask

    task automatic test_carry_bubble();
        logic [31:0] exp_cnt [5];
        logic        exp_vld [5];
        logic        exp_cp  [5];
        exp_cnt = '{32'h0000FFFE, 32'h0000FFFF, 32'h00000000, 32'h00010000, 32'h00010001};
        exp_vld = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_cp  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        load = 1'b1; load_val = 32'h0000FFFE; out_ready = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== exp_vld[c] || carry_pend !== exp_cp[c]) begin
                failures++;
                $display("FAIL bubble_flags cyc=%0d valid=%b carry_pend=%b exp=%b,%b",
                         c, out_valid, carry_pend, exp_vld[c], exp_cp[c]);
            end
            if (exp_vld[c]) begin
                checks++;
                if (out_count !== exp_cnt[c]) begin
                    failures++; $display("FAIL bubble_count cyc=%0d got=%h exp=%h", c, out_count, exp_cnt[c]);
                end
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic        rdy     [5];
        logic [31:0] exp_cnt [5];
        rdy     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_cnt = '{32'h12340000, 32'h12340001, 32'h12340001, 32'h12340001, 32'h12340002};
        load = 1'b1; load_val = 32'h12340000; out_ready = 1'b0;
        tick();
        load = 1'b0;
        for (int c = 0; c < 5; c++) begin
            out_ready = rdy[c];
            checks++;
            if (out_valid !== 1'b1 || out_count !== exp_cnt[c]) begin
                failures++;
                $display("FAIL backpressure cyc=%0d valid=%b count=%h exp=1,%h", c, out_valid, out_count, exp_cnt[c]);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_count !== 32'h12340003) begin
            failures++; $display("FAIL backpressure_final got=%h exp=12340003", out_count);
        end
    endtask

    task automatic test_full_wrap();
        load = 1'b1; load_val = 32'hFFFFFFFF; out_ready = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_count !== 32'hFFFFFFFF || wrap !== 1'b0) begin
            failures++; $display("FAIL wrap_load valid=%b count=%h wrap=%b exp=1,ffffffff,0", out_valid, out_count, wrap);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || carry_pend !== 1'b1 || wrap !== 1'b0) begin
            failures++; $display("FAIL wrap_bubble valid=%b carry_pend=%b wrap=%b exp=0,1,0", out_valid, carry_pend, wrap);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_count !== 32'h0 || wrap !== 1'b1 || carry_pend !== 1'b0) begin
            failures++;
            $display("FAIL wrap_pulse valid=%b count=%h wrap=%b carry_pend=%b exp=1,00000000,1,0",
                     out_valid, out_count, wrap, carry_pend);
        end
        tick();
        checks++;
        if (wrap !== 1'b0 || out_count !== 32'h1) begin
            failures++; $display("FAIL wrap_after wrap=%b count=%h exp=0,00000001", wrap, out_count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_load_carry();
        load = 1'b1; load_val = 32'h0000FFFF; out_ready = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_count !== 32'h0000FFFF) begin
            failures++; $display("FAIL ldcarry_load valid=%b count=%h exp=1,0000ffff", out_valid, out_count);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (carry_pend !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL ldcarry_pend carry_pend=%b valid=%b exp=1,0", carry_pend, out_valid);
        end
        load = 1'b1; load_val = 32'h00000005; out_ready = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_count !== 32'h5 || carry_pend !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL ldcarry_result valid=%b count=%h carry_pend=%b wrap=%b exp=1,00000005,0,0",
                     out_valid, out_count, carry_pend, wrap);
        end
        tick();
        checks++;
        if (out_count !== 32'h5) begin
            failures++; $display("FAIL ldcarry_hold got=%h exp=00000005", out_count);
        end
    endtask

    task automatic test_stop_reset();
        load = 1'b1; load_val = 32'h00000010; out_ready = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_count !== 32'h10) begin
            failures++; $display("FAIL stop_load valid=%b count=%h exp=1,00000010", out_valid, out_count);
        end
        stop = 1'b1; out_ready = 1'b1;
        tick();
        stop = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (out_valid !== 1'b0 || out_count !== 32'h11) begin
                failures++; $display("FAIL stop_hold cyc=%0d valid=%b count=%h exp=0,00000011", c, out_valid, out_count);
            end
            tick();
        end
        // load and stop together: load wins.
        load = 1'b1; stop = 1'b1; load_val = 32'h00000020; out_ready = 1'b0;
        tick();
        load = 1'b0; stop = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_count !== 32'h20) begin
            failures++; $display("FAIL load_stop valid=%b count=%h exp=1,00000020", out_valid, out_count);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_count !== 32'h0 || wrap !== 1'b0 || carry_pend !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset valid=%b count=%h wrap=%b carry_pend=%b exp=0,00000000,0,0",
                     out_valid, out_count, wrap, carry_pend);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_carry_bubble();
        test_back_pressure();
        test_full_wrap();
        test_load_carry();
        test_stop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
